// File: rtl/miracle_joypad_host.sv
`default_nettype none
// ============================================================================
//  Module      : miracle_joypad_host
//  Description : Console-side initiator for the Miracle Piano joypad-port
//                protocol. Generates strobe / joypad_clock waveforms to either
//                send one byte to the keyboard adapter or poll one byte back.
//  Ports       : clk, reset         - master clock, synchronous active-high reset
//                cmd_valid/ready    - command handshake (accept in IDLE)
//                cmd_write          - 1 = write cmd_wdata, 0 = read poll
//                cmd_wdata          - byte to send
//                done               - one-cycle pulse at end of a transaction
//                rd_present/rd_data - result of the last read poll
//                strobe, joypad_clock - lines to the adapter
//                joypad_i           - adapter serial data line (raw level)
//  Revision    : 1.0 - initial release
// ============================================================================
module miracle_joypad_host #(
    parameter int READ_STROBE  = 144,
    parameter int WRITE_STROBE = 800,
    parameter int PHASE        = 12,
    parameter int GAP          = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_write,
    input  logic [7:0] cmd_wdata,
    output logic       cmd_ready,
    output logic       done,
    output logic       rd_present,
    output logic [7:0] rd_data,
    output logic       strobe,
    output logic       joypad_clock,
    input  logic       joypad_i
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_R_STROBE = 4'd1;
    localparam logic [3:0] S_R_SETTLE = 4'd2;
    localparam logic [3:0] S_R_CLK_HI = 4'd3;
    localparam logic [3:0] S_R_CLK_LO = 4'd4;
    localparam logic [3:0] S_W_STROBE = 4'd5;
    localparam logic [3:0] S_W_SETUP  = 4'd6;
    localparam logic [3:0] S_W_CLK_HI = 4'd7;
    localparam logic [3:0] S_W_CLK_LO = 4'd8;
    localparam logic [3:0] S_GAP      = 4'd9;

    // Each state lasts (load + 1) cycles: the counter is loaded on entry and
    // the state is left on the cycle it reads zero.
    localparam logic [15:0] c_read_load  = 16'(READ_STROBE - 1);
    localparam logic [15:0] c_write_load = 16'(WRITE_STROBE - 1);
    localparam logic [15:0] c_phase_load = 16'(PHASE - 1);
    localparam logic [15:0] c_gap_load   = 16'(GAP - 1);
    localparam logic [3:0]  c_last_bit   = 4'd7;

    logic [3:0]  r_state;
    logic [3:0]  w_state_next;
    logic [15:0] r_count;
    logic [15:0] w_count_next;
    logic [3:0]  r_bit;
    logic [3:0]  w_bit_next;
    logic        w_expire;
    logic [7:0]  r_wdata;
    logic        r_present;
    logic [6:0]  r_shift;

    logic        w_strobe_d;
    logic        w_clk_d;
    logic        w_ready_d;
    logic        w_done_d;

    function automatic logic [15:0] f_load(input logic [3:0] st);
        logic [15:0] v;
        v = 16'd0;
        case (st)
            S_R_STROBE:                                   v = c_read_load;
            S_W_STROBE:                                   v = c_write_load;
            S_R_SETTLE, S_R_CLK_HI, S_R_CLK_LO,
            S_W_SETUP,  S_W_CLK_HI, S_W_CLK_LO:           v = c_phase_load;
            S_GAP:                                        v = c_gap_load;
            default:                                      v = 16'd0;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / counter / bit-index logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_expire     = (r_count == 16'd0);

        case (r_state)
            S_IDLE: begin
                // cmd_ready is high exactly while in IDLE
                if (cmd_valid) begin
                    w_state_next = cmd_write ? S_W_STROBE : S_R_STROBE;
                end
            end
            S_R_STROBE: if (w_expire) w_state_next = S_R_SETTLE;
            S_R_SETTLE: begin
                if (w_expire) begin
                    w_state_next = S_R_CLK_HI;
                    w_bit_next   = 4'd0;
                end
            end
            S_R_CLK_HI: if (w_expire) w_state_next = S_R_CLK_LO;
            S_R_CLK_LO: begin
                if (w_expire) begin
                    if (r_bit == c_last_bit) begin
                        w_state_next = S_GAP;
                    end else begin
                        w_state_next = S_R_CLK_HI;
                        w_bit_next   = r_bit + 4'd1;
                    end
                end
            end
            S_W_STROBE: begin
                if (w_expire) begin
                    w_state_next = S_W_SETUP;
                    w_bit_next   = 4'd0;
                end
            end
            S_W_SETUP:  if (w_expire) w_state_next = S_W_CLK_HI;
            S_W_CLK_HI: if (w_expire) w_state_next = S_W_CLK_LO;
            S_W_CLK_LO: begin
                if (w_expire) begin
                    if (r_bit == c_last_bit) begin
                        w_state_next = S_GAP;
                    end else begin
                        w_state_next = S_W_SETUP;
                        w_bit_next   = r_bit + 4'd1;
                    end
                end
            end
            S_GAP:      if (w_expire) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase

        // Every transition changes state, so a state change means "load".
        if (w_state_next != r_state) begin
            w_count_next = f_load(w_state_next);
        end else if (r_count != 16'd0) begin
            w_count_next = r_count - 16'd1;
        end else begin
            w_count_next = r_count;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so registered outputs line up
    // with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        w_strobe_d = 1'b0;
        w_clk_d    = 1'b0;
        w_ready_d  = (w_state_next == S_IDLE);
        w_done_d   = ((r_state == S_R_CLK_LO) || (r_state == S_W_CLK_LO)) &&
                     (w_state_next == S_GAP);
        case (w_state_next)
            S_R_STROBE, S_W_STROBE: w_strobe_d = 1'b1;
            S_R_CLK_HI:             w_clk_d    = 1'b1;
            // MSB first: bit index n selects wdata[7-n], i.e. the inverted index
            S_W_SETUP, S_W_CLK_LO:  w_strobe_d = r_wdata[~w_bit_next[2:0]];
            S_W_CLK_HI: begin
                w_strobe_d = r_wdata[~w_bit_next[2:0]];
                w_clk_d    = 1'b1;
            end
            default: begin
                w_strobe_d = 1'b0;
                w_clk_d    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= 16'd0;
            r_bit        <= 4'd0;
            r_wdata      <= 8'h00;
            r_present    <= 1'b0;
            r_shift      <= 7'd0;
            strobe       <= 1'b0;
            joypad_clock <= 1'b0;
            cmd_ready    <= 1'b1;
            done         <= 1'b0;
            rd_present   <= 1'b0;
            rd_data      <= 8'h00;
        end else begin
            r_count      <= w_count_next;
            r_bit        <= w_bit_next;
            strobe       <= w_strobe_d;
            joypad_clock <= w_clk_d;
            cmd_ready    <= w_ready_d;
            done         <= w_done_d;

            if (r_state == S_IDLE && cmd_valid) begin
                r_wdata <= cmd_wdata;
            end

            // joypad_i is looked at only on these sample cycles
            if (r_state == S_R_SETTLE && w_expire) begin
                r_present <= joypad_i;
            end

            if (r_state == S_R_CLK_LO && w_expire) begin
                // data bits arrive d7 first and are active-low on the wire
                r_shift <= {r_shift[5:0], ~joypad_i};
                if (r_bit == c_last_bit) begin
                    rd_present <= r_present;
                    rd_data    <= {r_shift, ~joypad_i};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miracle_joypad_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_miracle_joypad_host
//  Description : Self-checking bench for miracle_joypad_host. A driver issues
//                commands and pushes expected results; a monitor measures the
//                waveforms and compares on every done pulse; an adapter model
//                answers read polls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_miracle_joypad_host;

    localparam int READ_STROBE  = 144;
    localparam int WRITE_STROBE = 800;
    localparam int PHASE        = 12;
    localparam int GAP          = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready;
    logic       done;
    logic       rd_present;
    logic [7:0] rd_data;
    logic       strobe;
    logic       joypad_clock;
    logic       joypad_i = 1'b0;

    miracle_joypad_host #(
        .READ_STROBE (READ_STROBE),
        .WRITE_STROBE(WRITE_STROBE),
        .PHASE       (PHASE),
        .GAP         (GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .cmd_ready   (cmd_ready),
        .done        (done),
        .rd_present  (rd_present),
        .rd_data     (rd_data),
        .strobe      (strobe),
        .joypad_clock(joypad_clock),
        .joypad_i    (joypad_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         write;
        logic [7:0] wdata;
        logic       present;
        logic [7:0] rdata;
        int         len;
    } exp_t;

    exp_t sb[$];

    int n_total = 0;
    int n_pass  = 0;

    // reference model state: result of the last read poll
    logic       mdl_present = 1'b0;
    logic [7:0] mdl_data    = 8'h00;

    // adapter stimulus for the current read
    bit         cur_write = 1'b0;
    logic [8:0] lv = 9'd0;   // wire levels: presence, then ~d7 .. ~d0

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Adapter model: answers reads, noise on joypad_i outside sample windows
    // ------------------------------------------------------------------
    bit a_active = 0, a_phase = 0, a_prev_s = 0, a_prev_c = 0;
    int a_idx = 0;
    always @(negedge clk) begin
        if (reset || done) begin
            a_active = 0;
            a_phase  = 0;
            joypad_i = 1'($urandom);
        end else begin
            if (strobe && !a_prev_s) a_active = !cur_write;
            if (a_active && a_prev_s && !strobe) begin
                joypad_i = lv[8];
                a_idx    = 1;
                a_phase  = 1;
            end else if (a_phase && a_prev_c && !joypad_clock) begin
                if (a_idx <= 8) joypad_i = lv[8 - a_idx];
                a_idx++;
            end else if (!a_phase || joypad_clock) begin
                joypad_i = 1'($urandom);
            end
        end
        a_prev_s = strobe;
        a_prev_c = joypad_clock;
    end

    // ------------------------------------------------------------------
    // Monitor: waveform measurement and scoreboard comparison
    // ------------------------------------------------------------------
    int cyc = 0, t_rise = 0, srun = 0, pulses = 0, hi_run = 0;
    int last_sc = 0, last_rise = -1000, low_run = 1000;
    bit in_txn = 0, first_run = 0, m_write = 0, prev_s = 0, prev_c = 0;
    logic [7:0] wcap = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            in_txn  = 0;
            prev_s  = 0;
            prev_c  = 0;
            low_run = 1000;
        end else begin
            if (strobe && !prev_s && !in_txn) begin
                chk("gap_before_strobe", low_run >= GAP, 1);
                chk("strobe_has_command", sb.size() > 0, 1);
                in_txn    = 1;
                m_write   = (sb.size() > 0) ? sb[0].write : 1'b0;
                t_rise    = cyc;
                srun      = 0;
                first_run = 1;
                pulses    = 0;
                wcap      = 8'h00;
                last_rise = -1000;
            end
            if (strobe != prev_s) begin
                last_sc = cyc;
                if (in_txn && m_write && !first_run)
                    chk("write_hold", (cyc - last_rise) >= PHASE, 1);
            end
            if (in_txn && first_run) begin
                if (strobe) srun++;
                else first_run = 0;
            end
            if (joypad_clock && !prev_c) begin
                pulses++;
                hi_run    = 0;
                last_rise = cyc;
                if (in_txn && m_write) begin
                    wcap = {wcap[6:0], strobe};
                    chk("write_setup", (cyc - last_sc) >= PHASE, 1);
                end
            end
            if (joypad_clock) hi_run++;
            if (!joypad_clock && prev_c) chk("clock_high_len", hi_run, PHASE);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("txn_length", cyc - t_rise, e.len);
                    chk("clock_pulses", pulses, 8);
                    chk("rd_present", rd_present, e.present);
                    chk("rd_data", rd_data, e.rdata);
                    chk("strobe_low_at_done", strobe, 0);
                    chk("clock_low_at_done", joypad_clock, 0);
                    chk("ready_low_at_done", cmd_ready, 0);
                    if (e.write) begin
                        chk("write_capture", wcap, e.wdata);
                        if (e.wdata[7]) chk("write_strobe_len_min", srun >= WRITE_STROBE, 1);
                        else            chk("write_strobe_len", srun, WRITE_STROBE);
                    end else begin
                        chk("read_strobe_len", srun, READ_STROBE);
                    end
                end
                in_txn = 0;
            end
            low_run = strobe ? 0 : low_run + 1;
            prev_s  = strobe;
            prev_c  = joypad_clock;
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit w, input logic [7:0] d, input bit pres, input bit hold);
        exp_t e;
        int   n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_wdata = w ? d : 8'($urandom);
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        e.write = w;
        e.wdata = d;
        if (w) begin
            e.len = WRITE_STROBE + 24 * PHASE;
        end else begin
            mdl_present = pres;
            mdl_data    = d;
            lv          = {pres, ~d};
            e.len       = READ_STROBE + 17 * PHASE;
        end
        e.present = mdl_present;
        e.rdata   = mdl_data;
        cur_write = w;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_strobe", strobe, 0);
        chk("reset_clock", joypad_clock, 0);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_done", done, 0);
        chk("reset_rd_present", rd_present, 0);
        chk("reset_rd_data", rd_data, 8'h00);

        send(1'b0, 8'hA5, 1'b1, 1'b0);   // present, 0xA5
        send(1'b0, 8'hFF, 1'b0, 1'b0);   // joypad_i low throughout
        send(1'b1, 8'h90, 1'b0, 1'b0);
        send(1'b1, 8'hFF, 1'b0, 1'b1);   // valid held into the next read
        send(1'b0, 8'h3C, 1'b1, 1'b0);

        // reset during W_CLK_HI of bit 3 (fifth bit sent)
        send(1'b1, 8'h6B, 1'b0, 1'b0);   // returns at strobe-rise cycle
        repeat (WRITE_STROBE + 12 * PHASE + PHASE + 5) @(negedge clk);
        chk("pre_reset_clock_high", joypad_clock, 1);
        reset = 1'b1;
        sb.delete();
        mdl_present = 1'b0;
        mdl_data    = 8'h00;
        @(negedge clk);
        chk("midreset_strobe", strobe, 0);
        chk("midreset_clock", joypad_clock, 0);
        chk("midreset_done", done, 0);
        chk("midreset_ready", cmd_ready, 1);
        chk("midreset_rd_data", rd_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(1'b0, 8'h5A, 1'b1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            send(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        cmd_valid = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_complete", sb.size(), 0);
        repeat (GAP + 10) @(negedge clk);
        chk("final_ready", cmd_ready, 1);
        chk("final_strobe", strobe, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/miracle_joypad_host.md
Name: miracle_joypad_host

Overview:
- Console-side initiator for the Miracle Piano joypad-port protocol. It generates strobe and joypad_clock waveforms and sends one byte to the keyboard adapter, or polls one byte from it.
- Sits between a CPU-side command interface (test harness or host logic) and the adapter's strobe/clock/data lines.
- Protocol timing is counted in clk cycles; the defaults assume the 21.477 MHz master clock.

Parameters:
- READ_STROBE, 144, strobe-high length in cycles for a read transaction; must be <256.
- WRITE_STROBE, 800, strobe-high length in cycles for a write transaction; must be >=793.
- PHASE, 12, cycles per joypad_clock half-period, also used as data setup time; must be >=3.
- GAP, 24, idle cycles forced between transactions.

Ports:
- clk in 1: master clock, 21.477 MHz.
- reset in 1: synchronous, active-high.
- cmd_valid in 1: command request.
- cmd_write in 1: 1 = write byte, 0 = read poll.
- cmd_wdata in 8: byte to send.
- cmd_ready out 1: high in IDLE; a command is accepted when cmd_valid && cmd_ready.
- done out 1: one-cycle pulse at the end of a transaction.
- rd_present out 1: read result, 1 = adapter returned a byte.
- rd_data out 8: read result byte.
- strobe out 1: to adapter.
- joypad_clock out 1: to adapter.
- joypad_i in 1: adapter serial data line, raw level.

Behaviour:
- Reset values: strobe=0, joypad_clock=0, cmd_ready=1, done=0, rd_present=0, rd_data=0x00, state IDLE, counters 0.
- Reset mid-transaction: at the next edge, strobe and clock go low and state returns to IDLE. No done pulse; rd_* keep their reset values.
- All outputs are registered. Use a single 16-bit down-counter; bit index is 4 bits.
- Accept: cmd_valid && cmd_ready in IDLE latches cmd_write and cmd_wdata. strobe rises on the next cycle. cmd_ready stays low until the state is back in IDLE after GAP. cmd_* are ignored while busy.
- Read sequence:
  - R_STROBE: strobe=1 for exactly READ_STROBE cycles, then strobe=0.
  - R_SETTLE: wait PHASE cycles, then sample joypad_i as bit 0, the presence flag (1 = byte present).
  - For i=1..8: R_CLK_HI holds joypad_clock=1 for PHASE cycles; R_CLK_LO holds joypad_clock=0 for PHASE cycles; sample joypad_i on the last R_CLK_LO cycle.
  - Samples 1..8 are data bits d7..d0 and are inverted: d = ~joypad_i.
  - After the 8th sample: rd_present and rd_data update together, done pulses in the same cycle, then GAP.
  - Total read length = READ_STROBE + PHASE + 16*PHASE cycles from strobe rise to done.
- Write sequence:
  - W_STROBE: strobe=1 for WRITE_STROBE cycles. The adapter enters write mode at 792 continuous high cycles or on the strobe fall.
  - For bits b7..b0, MSB first: W_SETUP drives strobe=bit with clock low for PHASE cycles; W_CLK_HI holds joypad_clock=1 for PHASE cycles with strobe held; W_CLK_LO holds joypad_clock=0 for PHASE cycles.
  - The adapter captures strobe on each joypad_clock rising edge. strobe must not change within PHASE cycles of a rising edge.
  - After the 8th W_CLK_LO: strobe=0, done pulses, then GAP. rd_* are unchanged.
  - Total write length = WRITE_STROBE + 24*PHASE cycles to done.
- GAP: strobe=0, clock=0 for GAP cycles, then IDLE with cmd_ready=1. This guarantees a clean strobe rising edge for the next command.
- Boundaries:
  - Back-to-back commands are always separated by at least GAP idle cycles.
  - cmd_valid held high continuously yields one transaction per accept, never two per accept.
  - joypad_i is used only at its sample points; toggles at any other time have no effect.
  - Counters never wrap; every state loads its count on entry.

Test Plan:
- Reset then idle: strobe=0, joypad_clock=0, cmd_ready=1, done=0, rd_data=0x00.
- Read, adapter model returns presence=1 and data 0xA5 (joypad_i levels 1,0,1,0,1,1,0,1,0) -> strobe high exactly 144 cycles, 8 clock pulses each 12 high/12 low, done with rd_present=1, rd_data=0xA5, 144+12+192 cycles after strobe rise.
- Read with joypad_i=0 throughout -> rd_present=0, rd_data=0xFF.
- Write 0x90 into an adapter receiver model -> strobe high 800 cycles, 8 rising edges capture 1,0,0,1,0,0,0,0, model stores 0x90, done after 800+288 cycles, strobe ends low.
- Write 0xFF then immediate read with cmd_valid held high -> strobe stays high through the write bits, then at least 24 cycles low before the read strobe rises; each command accepted once.
- Assert reset during W_CLK_HI of bit 3 -> next cycle strobe=0, joypad_clock=0, no done; a following read completes normally.
